// File: rtl/sevenseg_mux.sv
// sevenseg_mux: four-digit multiplexed seven-segment driver.
// A 2-bit scan index selects one digit at a time. The anode and segment
// outputs are registered from the post-update index, so a change in the
// index or in a digit value reaches the outputs one clock later.
// Optional feature: define SEVENSEG_LZ_BLANK_EN to blank leading zeros.
// The rightmost digit is never blanked, and blanked digits keep their
// anode slot in the scan.
module sevenseg_mux #(
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_en,
  input  logic [3:0] d3,
  input  logic [3:0] d2,
  input  logic [3:0] d1,
  input  logic [3:0] d0,
  output logic [3:0] an,
  output logic [6:0] seg
);

  localparam logic [3:0] AN_OFF  = (AN_ACTIVE_LOW  != 0) ? 4'hF  : 4'h0;
  localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  // Hex digit to segment pattern, active-low form, bit order gfedcba.
  function automatic logic [6:0] seg_decode_n(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // One-hot-low anode pattern for a scan index.
  function automatic logic [3:0] an_decode_n(input logic [1:0] i);
    return ~(4'b0001 << i);
  endfunction

  logic [1:0] r_idx;
  logic [3:0] r_an_p1;
  logic [6:0] r_seg_p1;

  logic [1:0] w_idx_nx;
  logic [3:0] w_digit;
  logic       w_blank;
  logic [3:0] w_an_n;
  logic [6:0] w_seg_n;
  logic [3:0] w_an_nx;
  logic [6:0] w_seg_nx;

  // Next scan index: step with wrap on each enabled clock, otherwise hold.
  always_comb begin
    w_idx_nx = r_idx;
    if (scan_en) w_idx_nx = r_idx + 2'd1;
  end

  // Select the digit addressed by the post-update index.
  always_comb begin
    case (w_idx_nx)
      2'd0:    w_digit = d0;
      2'd1:    w_digit = d1;
      2'd2:    w_digit = d2;
      default: w_digit = d3;
    endcase
  end

  // Leading-zero blanking: digit i>0 goes dark when it and all higher digits are 0.
  always_comb begin
    w_blank = 1'b0;
`ifdef SEVENSEG_LZ_BLANK_EN
    case (w_idx_nx)
      2'd3:    w_blank = (d3 == 4'h0);
      2'd2:    w_blank = (d3 == 4'h0) && (d2 == 4'h0);
      2'd1:    w_blank = (d3 == 4'h0) && (d2 == 4'h0) && (d1 == 4'h0);
      default: w_blank = 1'b0;
    endcase
`endif
  end

  // Build the output patterns in active-low form, then apply polarity.
  always_comb begin
    w_an_n   = an_decode_n(w_idx_nx);
    w_seg_n  = w_blank ? 7'h7F : seg_decode_n(w_digit);
    w_an_nx  = (AN_ACTIVE_LOW  != 0) ? w_an_n  : ~w_an_n;
    w_seg_nx = (SEG_ACTIVE_LOW != 0) ? w_seg_n : ~w_seg_n;
  end

  // Scan index and registered outputs; reset blanks the display and ignores scan_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx    <= 2'd0;
      r_an_p1  <= AN_OFF;
      r_seg_p1 <= SEG_OFF;
    end else begin
      r_idx    <= w_idx_nx;
      r_an_p1  <= w_an_nx;
      r_seg_p1 <= w_seg_nx;
    end
  end

  assign an  = r_an_p1;
  assign seg = r_seg_p1;

endmodule

// File: tb/tb_sevenseg_mux.sv
// Testbench for sevenseg_mux (default polarities: active-low anodes and segments).
module tb_sevenseg_mux;

  localparam int AN_AL  = 1;
  localparam int SEG_AL = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scan_en = 1'b0;
  logic [3:0] d3 = 4'h0, d2 = 4'h0, d1 = 4'h0, d0 = 4'h0;
  logic [3:0] an;
  logic [6:0] seg;

  int n_checks = 0;
  int n_errors = 0;

  sevenseg_mux #(.AN_ACTIVE_LOW(AN_AL), .SEG_ACTIVE_LOW(SEG_AL)) dut (
    .clk(clk), .rst(rst), .scan_en(scan_en),
    .d3(d3), .d2(d2), .d1(d1), .d0(d0),
    .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  // Reference glyph table (active-low gfedcba).
  logic [6:0] glyph [16];
  initial begin
    glyph[0]  = 7'h40; glyph[1]  = 7'h79; glyph[2]  = 7'h24; glyph[3]  = 7'h30;
    glyph[4]  = 7'h19; glyph[5]  = 7'h12; glyph[6]  = 7'h02; glyph[7]  = 7'h78;
    glyph[8]  = 7'h00; glyph[9]  = 7'h10; glyph[10] = 7'h08; glyph[11] = 7'h03;
    glyph[12] = 7'h46; glyph[13] = 7'h21; glyph[14] = 7'h06; glyph[15] = 7'h0E;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: slot number as an integer, displayed value as a 16-bit number.
  int         m_slot = 0;
  logic [3:0] m_an;
  logic [6:0] m_seg;
  bit         m_valid = 1'b0;

  always @(posedge clk) begin : model
    int slot;
    int value;
    int digit;
    logic [6:0] g;
    logic [3:0] a;
    if (rst) begin
      m_slot <= 0;
      m_an   <= (AN_AL  != 0) ? 4'hF  : 4'h0;
      m_seg  <= (SEG_AL != 0) ? 7'h7F : 7'h00;
    end else begin
      slot  = scan_en ? (m_slot + 1) % 4 : m_slot;
      value = {d3, d2, d1, d0};
      digit = (value >> (4 * slot)) % 16;
      g     = glyph[digit];
`ifdef SEVENSEG_LZ_BLANK_EN
      if (slot > 0 && (value >> (4 * slot)) == 0) g = 7'h7F;
`endif
      a = 4'hF;
      a[slot] = 1'b0;
      m_slot <= slot;
      m_an   <= (AN_AL  != 0) ? a : ~a;
      m_seg  <= (SEG_AL != 0) ? g : ~g;
    end
    m_valid <= 1'b1;
  end

  // Compare DUT against the model on every falling edge once the model is primed.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_an",  {4'h0, an},  {4'h0, m_an});
      chk("model_seg", {1'b0, seg}, {1'b0, m_seg});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [6:0] sweep [16];
  logic [6:0] lz_seg;

  initial begin
    sweep = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reset held 10 clocks with scan_en high: scan must not move.
    rst = 1'b1; scan_en = 1'b1;
    repeat (10) tick();
    chk("reset_an",  {4'h0, an},  8'h0F);
    chk("reset_seg", {1'b0, seg}, 8'h7F);

    // Release with scan_en low: digit 0 shown.
    rst = 1'b0; scan_en = 1'b0; d0 = 4'h0;
    tick();
    chk("release_an",  {4'h0, an},  8'h0E);
    chk("release_seg", {1'b0, seg}, 8'h40);

    // Decode sweep on slot 0.
    for (int v = 0; v < 16; v++) begin
      d0 = v[3:0];
      tick();
      chk($sformatf("sweep_%0h", v), {1'b0, seg}, {1'b0, sweep[v]});
    end

    // Scan order with d3..d0 = 0,1,2,3.
    d3 = 4'h0; d2 = 4'h1; d1 = 4'h2; d0 = 4'h3;
    tick();
    chk("scan0_seg", {1'b0, seg}, 8'h30);
    scan_en = 1'b1;
    tick();
    chk("scan1_an",  {4'h0, an},  8'h0D);
    chk("scan1_seg", {1'b0, seg}, 8'h24);
    tick();
    chk("scan2_an",  {4'h0, an},  8'h0B);
    chk("scan2_seg", {1'b0, seg}, 8'h79);
    tick();
    chk("scan3_an",  {4'h0, an},  8'h07);
`ifdef SEVENSEG_LZ_BLANK_EN
    chk("scan3_seg", {1'b0, seg}, 8'h7F);
`else
    chk("scan3_seg", {1'b0, seg}, 8'h40);
`endif
    tick();
    chk("wrap_an",  {4'h0, an},  8'h0E);
    chk("wrap_seg", {1'b0, seg}, 8'h30);

    // Live update of d0 while scanning.
    d0 = 4'h9;
    repeat (4) tick();
    chk("live9_an",  {4'h0, an},  8'h0E);
    chk("live9_seg", {1'b0, seg}, 8'h10);
    d0 = 4'h5;
    repeat (4) tick();
    chk("live5_seg", {1'b0, seg}, 8'h12);

    // Stall at slot 2, then resume.
    repeat (2) tick();
    chk("stall_pre_an", {4'h0, an}, 8'h0B);
    scan_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_an", {4'h0, an}, 8'h0B);
    end
    scan_en = 1'b1;
    tick();
    chk("resume_an", {4'h0, an}, 8'h07);

    // Reset mid-scan, then first enabled clock selects slot 1.
    rst = 1'b1;
    tick();
    chk("midrst_an",  {4'h0, an},  8'h0F);
    chk("midrst_seg", {1'b0, seg}, 8'h7F);
    rst = 1'b0;
    tick();
    chk("postrst_an", {4'h0, an}, 8'h0D);

    // Leading zeros: d3..d0 = 0,0,1,0.
    d3 = 4'h0; d2 = 4'h0; d1 = 4'h1; d0 = 4'h0;
`ifdef SEVENSEG_LZ_BLANK_EN
    lz_seg = 7'h7F;
`else
    lz_seg = 7'h40;
`endif
    tick();
    chk("lz2_an",  {4'h0, an},  8'h0B);
    chk("lz2_seg", {1'b0, seg}, {1'b0, lz_seg});
    tick();
    chk("lz3_an",  {4'h0, an},  8'h07);
    chk("lz3_seg", {1'b0, seg}, {1'b0, lz_seg});
    tick();
    chk("lz0_seg", {1'b0, seg}, 8'h40);
    tick();
    chk("lz1_seg", {1'b0, seg}, 8'h79);

    // All zeros: d0 still lit.
    d1 = 4'h0;
    repeat (3) tick();
    chk("zero_d0_seg", {1'b0, seg}, 8'h40);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
